// File: rtl/time_display_driver.sv
// -----------------------------------------------------------------------------
// time_display_driver
//
// Drives a 6-digit multiplexed 7-segment display (HH.MM.SS) from binary time
// fields. Once per scan frame the inputs are snapshotted and converted to BCD
// by a multi-cycle shift-add-3 (double-dabble) engine. All three fields are
// converted in parallel. The display registers update in a single cycle, so a
// frame never shows a mix of old and new digits.
//
// Ports:
//   i_clk    system clock
//   i_rst    synchronous active-high reset
//   i_sec    binary seconds (0..63 accepted, no clamping)
//   i_min    binary minutes (0..63 accepted, no clamping)
//   i_hr     binary hours   (0..31 accepted, no clamping)
//   i_blank  forces every digit dark while high; the scan keeps running
//   o_seg    segments {g,f,e,d,c,b,a}, active-low, registered
//   o_dp     decimal point, active-low, lit on digits 2 and 4
//   o_an     one-hot active-low digit enables; bit n selects digit n
//   o_frame  one-cycle pulse at the start of each scan frame
//
// Parameter:
//   SCAN_DIV clock cycles each digit stays lit (2 or more)
// -----------------------------------------------------------------------------
module time_display_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_sec,
    input  logic [5:0] i_min,
    input  logic [4:0] i_hr,
    input  logic       i_blank,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic [5:0] o_an,
    output logic       o_frame
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } conv_state_t;

    conv_state_t       state, state_next;

    logic [DIV_W-1:0]  div;
    logic [2:0]        idx;
    logic              load_req;
    logic [2:0]        iter;

    // Binary shift registers and BCD scratch, one pair per field.
    logic [5:0]        sec_bin, min_bin, hr_bin;
    logic [7:0]        sec_bcd, min_bcd, hr_bcd;

    // Display nibbles, digit n at disp[n].
    logic [5:0][3:0]   disp;
    logic [3:0]        sel_nib;

    logic              div_tc;
    logic              frame_wrap;

    assign div_tc     = (div == DIV_LAST);
    assign frame_wrap = div_tc && (idx == 3'd5);

    // Shift-add-3 correction: any BCD nibble of 5 or more gets +3 so that the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [7:0] dabble_adjust(input logic [7:0] bcd);
        logic [3:0] lo, hi;
        lo = bcd[3:0];
        hi = bcd[7:4];
        if (lo >= 4'd5) lo = lo + 4'd3;
        if (hi >= 4'd5) hi = hi + 4'd3;
        return {hi, lo};
    endfunction

    function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next-state gets a default before the case so no path leaves it
    // unassigned; a missing default in combinational logic infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (load_req)       state_next = ST_CONV;
            ST_CONV: if (iter == 3'd5)   state_next = ST_DONE;
            ST_DONE:                     state_next = ST_IDLE;
            default:                     state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------- scan and conversion
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div      <= '0;
            idx      <= '0;
            load_req <= 1'b1;
            iter     <= '0;
            sec_bin  <= '0;
            min_bin  <= '0;
            hr_bin   <= '0;
            sec_bcd  <= '0;
            min_bcd  <= '0;
            hr_bcd   <= '0;
            disp     <= '0;
        end else begin
            // Divider and digit index.
            if (div_tc) begin
                div <= '0;
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                div <= div + 1'b1;
            end

            // A new frame request wins over the IDLE clear so it is never lost.
            if (frame_wrap) begin
                load_req <= 1'b1;
            end else if (state == ST_IDLE && load_req) begin
                load_req <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (load_req) begin
                        sec_bin <= i_sec;
                        min_bin <= i_min;
                        hr_bin  <= {1'b0, i_hr};
                        sec_bcd <= '0;
                        min_bcd <= '0;
                        hr_bcd  <= '0;
                        iter    <= '0;
                    end
                end
                ST_CONV: begin
                    sec_bcd <= {dabble_adjust(sec_bcd) << 1} | {7'd0, sec_bin[5]};
                    min_bcd <= {dabble_adjust(min_bcd) << 1} | {7'd0, min_bin[5]};
                    hr_bcd  <= {dabble_adjust(hr_bcd)  << 1} | {7'd0, hr_bin[5]};
                    sec_bin <= sec_bin << 1;
                    min_bin <= min_bin << 1;
                    hr_bin  <= hr_bin  << 1;
                    iter    <= iter + 3'd1;
                end
                ST_DONE: begin
                    disp <= {hr_bcd[7:4],  hr_bcd[3:0],
                             min_bcd[7:4], min_bcd[3:0],
                             sec_bcd[7:4], sec_bcd[3:0]};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_nib = disp[idx];
    end

    // ------------------------------------------------------ output register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_an    <= 6'b111111;
            o_seg   <= 7'b1111111;
            o_dp    <= 1'b1;
            o_frame <= 1'b0;
        end else begin
            o_frame <= frame_wrap;
            if (i_blank) begin
                o_an  <= 6'b111111;
                o_seg <= 7'b1111111;
                o_dp  <= 1'b1;
            end else begin
                o_an  <= ~(6'b000001 << idx);
                o_seg <= seg_pattern(sel_nib);
                o_dp  <= ~((idx == 3'd2) || (idx == 3'd4));
            end
        end
    end

endmodule
